// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
// Keeps the register-index width and pipeline-control bundle in one place.
package hazard_ctrl_pkg;

  localparam int                REG_W  = 5;
  localparam logic [REG_W-1:0]  REG_X0 = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Pipeline control bundle driven toward PC, IF/ID and ID/EX
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic noop;
    logic freeze;
  } ctl_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter for pipeline statistics.
// Holds at all-ones instead of wrapping; clear wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller on the consumer side of ID/EX: load-use bubbles,
// branch flushes, memory-busy freeze, saturating statistics and a sticky timeout.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] IDRs1_i,
  input  logic [REG_W-1:0] IDRs2_i,
  input  logic             EXMemRead_i,
  input  logic [REG_W-1:0] EXRd_i,
  input  logic             BranchTaken_i,
  input  logic             MemReq_i,
  input  logic             MemReady_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             NoOp_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FreezeCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o,
  output logic             Timeout_o
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(TIMEOUT - 1);

  logic              hazard_lu;
  logic              mem_busy;
  logic              stall_fire;
  logic              freeze_fire;
  logic              flush_fire;
  state_t            state;
  state_t            state_next;
  ctl_t              ctl;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;

  // x0 is hardwired zero, so a load targeting it can never feed a consumer
  assign hazard_lu = EXMemRead_i && (EXRd_i != REG_X0) &&
                     ((EXRd_i == IDRs1_i) || (EXRd_i == IDRs2_i));
  assign mem_busy  = MemReq_i && !MemReady_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mem_busy)   state_next = MEM_WAIT;
      MEM_WAIT: if (MemReady_i) state_next = RUN;
      default:                  state_next = RUN;
    endcase
  end

  // Priority decode; a branch under a load-use bubble is dropped and re-resolves next cycle
  always_comb begin
    ctl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, noop: 1'b0, freeze: 1'b0};
    if (!rst_i) begin
      ctl.pc_write   = 1'b0;
      ctl.ifid_write = 1'b0;
      ctl.noop       = 1'b1;
    end else if (mem_busy) begin
      ctl.pc_write   = 1'b0;
      ctl.ifid_write = 1'b0;
      ctl.freeze     = 1'b1;
    end else if (hazard_lu) begin
      ctl.pc_write   = 1'b0;
      ctl.ifid_write = 1'b0;
      ctl.noop       = 1'b1;
    end else if (BranchTaken_i) begin
      ctl.ifid_flush = 1'b1;
    end
  end

  assign PCWrite_o   = ctl.pc_write;
  assign IFIDWrite_o = ctl.ifid_write;
  assign IFIDFlush_o = ctl.ifid_flush;
  assign NoOp_o      = ctl.noop;
  assign Freeze_o    = ctl.freeze;

  assign freeze_fire = rst_i && mem_busy;
  assign stall_fire  = rst_i && !mem_busy && hazard_lu;
  assign flush_fire  = rst_i && !mem_busy && !hazard_lu && BranchTaken_i;

  // Timeout trips on the edge that completes the TIMEOUT-th consecutive busy cycle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (mem_busy) begin
      if (wait_cnt != WAIT_MAX)   wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt >= WAIT_TRIP)  timeout  <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign Timeout_o = timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clear (!rst_i),
    .inc   (stall_fire),
    .count (StallCnt_o)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk_i),
    .clear (!rst_i),
    .inc   (freeze_fire),
    .count (FreezeCnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clear (!rst_i),
    .inc   (flush_fire),
    .count (FlushCnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: directed vectors push hand-computed expectations, a negedge
// monitor pops and compares. dut_a uses defaults, dut_b uses CNT_W=2, TIMEOUT=4.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam logic [4:0] C_RST   = 5'b00010;
  localparam logic [4:0] C_NOP   = 5'b00010;
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_FLUSH = 5'b11100;
  localparam logic [4:0] C_FRZ   = 5'b00001;

  typedef struct {
    bit         sel;
    logic [4:0] ctl;
    int         stall;
    int         frz;
    int         flush;
    int         to;
    int         st;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 0, a_mr = 0, a_br = 0, a_mreq = 0, a_mrdy = 0;
  logic [4:0] a_rs1 = 0, a_rs2 = 0, a_rd = 0;
  logic       a_pc, a_iw, a_fl, a_no, a_fz, a_to;
  logic [15:0] a_scnt, a_fcnt, a_bcnt;

  logic       b_rst = 0, b_mr = 0, b_br = 0, b_mreq = 0, b_mrdy = 0;
  logic [4:0] b_rs1 = 0, b_rs2 = 0, b_rd = 0;
  logic       b_pc, b_iw, b_fl, b_no, b_fz, b_to;
  logic [1:0] b_scnt, b_fcnt, b_bcnt;

  hazard_ctrl dut_a (
    .clk_i(clk), .rst_i(a_rst), .IDRs1_i(a_rs1), .IDRs2_i(a_rs2),
    .EXMemRead_i(a_mr), .EXRd_i(a_rd), .BranchTaken_i(a_br),
    .MemReq_i(a_mreq), .MemReady_i(a_mrdy),
    .PCWrite_o(a_pc), .IFIDWrite_o(a_iw), .IFIDFlush_o(a_fl), .NoOp_o(a_no),
    .Freeze_o(a_fz), .StallCnt_o(a_scnt), .FreezeCnt_o(a_fcnt),
    .FlushCnt_o(a_bcnt), .Timeout_o(a_to)
  );

  hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .IDRs1_i(b_rs1), .IDRs2_i(b_rs2),
    .EXMemRead_i(b_mr), .EXRd_i(b_rd), .BranchTaken_i(b_br),
    .MemReq_i(b_mreq), .MemReady_i(b_mrdy),
    .PCWrite_o(b_pc), .IFIDWrite_o(b_iw), .IFIDFlush_o(b_fl), .NoOp_o(b_no),
    .Freeze_o(b_fz), .StallCnt_o(b_scnt), .FreezeCnt_o(b_fcnt),
    .FlushCnt_o(b_bcnt), .Timeout_o(b_to)
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a control decision; compare away from the edge
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      item_t it;
      it = sbq.pop_front();
      if (!it.sel) begin
        cmp("a_ctl",   int'({a_pc, a_iw, a_fl, a_no, a_fz}), int'(it.ctl));
        cmp("a_stall", int'(a_scnt), it.stall);
        cmp("a_frz",   int'(a_fcnt), it.frz);
        cmp("a_flush", int'(a_bcnt), it.flush);
        cmp("a_to",    int'(a_to),   it.to);
        cmp("a_state", int'(dut_a.state), it.st);
      end else begin
        cmp("b_ctl",   int'({b_pc, b_iw, b_fl, b_no, b_fz}), int'(it.ctl));
        cmp("b_stall", int'(b_scnt), it.stall);
        cmp("b_frz",   int'(b_fcnt), it.frz);
        cmp("b_flush", int'(b_bcnt), it.flush);
        cmp("b_to",    int'(b_to),   it.to);
        cmp("b_state", int'(dut_b.state), it.st);
      end
    end
  end

  task automatic step(input bit sel, input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit mr, input logic [4:0] rd, input bit br, input bit mreq,
                      input bit mrdy, input logic [4:0] ctl, input int s, input int f,
                      input int b, input int to, input int st);
    item_t it;
    @(posedge clk);
    #1;
    if (!sel) begin
      a_rst = rst; a_rs1 = rs1; a_rs2 = rs2; a_mr = mr; a_rd = rd;
      a_br = br; a_mreq = mreq; a_mrdy = mrdy;
    end else begin
      b_rst = rst; b_rs1 = rs1; b_rs2 = rs2; b_mr = mr; b_rd = rd;
      b_br = br; b_mreq = mreq; b_mrdy = mrdy;
    end
    it.sel = sel; it.ctl = ctl; it.stall = s; it.frz = f; it.flush = b; it.to = to; it.st = st;
    sbq.push_back(it);
  endtask

  localparam int R = 0;
  localparam int W = 1;

  initial begin
    // dut_a: reset, load-use, x0, branch vs hazard, memory freeze
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0, 0, R);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0, 0, R);
    step(0, 1, 0, 5, 1, 5, 0, 0, 0, C_NOP,   0, 0, 0, 0, R);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   1, 0, 0, 0, R);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, C_RUN,   1, 0, 0, 0, R);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   1, 0, 0, 0, R);
    step(0, 1, 7, 0, 1, 7, 1, 0, 0, C_NOP,   1, 0, 0, 0, R);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, C_FLUSH, 2, 0, 0, 0, R);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2, 0, 1, 0, R);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 2, i, 1, 0, (i == 0) ? R : W);
    step(0, 1, 3, 0, 1, 3, 0, 1, 1, C_NOP,   2, 4, 1, 0, W);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   3, 4, 1, 0, R);
    step(0, 1, 0, 4, 1, 4, 1, 1, 0, C_FRZ,   3, 4, 1, 0, R);
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, C_RUN,   3, 5, 1, 0, W);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   3, 5, 1, 0, R);

    // dut_b: timeout, saturation, reset mid-wait
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,   0, 0, 0, 0, R);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0, 0, R);
    for (int i = 0; i < 6; i++)
      step(1, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, (i > 3) ? 3 : i, 0, (i >= 4) ? 1 : 0,
           (i == 0) ? R : W);
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, C_RUN,   0, 3, 0, 1, W);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 3, 0, 1, R);
    step(1, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ,   0, 3, 0, 1, R);
    step(1, 1, 0, 0, 0, 0, 0, 1, 0, C_FRZ,   0, 3, 0, 1, W);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, C_RST,   0, 3, 0, 1, W);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 0, 0, R);
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 0, 0, 0, 1, 0, 0, C_FLUSH, 0, 0, (i > 3) ? 3 : i, 0, R);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0, 3, 0, R);

    for (int n = 0; n < 10 && sbq.size() > 0; n++) @(posedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
